// File: rtl/lp_pkg.sv
// ---------------------------------------------------------------------------
// lp_pkg
// Shared constants for the two-thirds lowpass output path.
//   NSAMPS   : samples carried per clock on the SSR4 stream
//   LP_NBITS : width of one filter output sample
// ---------------------------------------------------------------------------
package lp_pkg;
    localparam int NSAMPS   = 4;
    localparam int LP_NBITS = 13;
endpackage

// File: rtl/ssr4_lane_shift.sv
// ---------------------------------------------------------------------------
// ssr4_lane_shift
// Sub-clock (lane granular) delay of an SSR4 stream by 0..3 samples.
// Registers the previous input word and selects, per output lane k,
//   sh[k] = (k >= sel) ? dat[k-sel] : prev[k-sel+4]
// The result is registered, so this stage adds one clock of latency.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   dat_i        : current SSR4 word, lane 0 oldest
//   sel_i        : lane shift S (0..3)
//   sh_o         : shifted word (registered)
// ---------------------------------------------------------------------------
module ssr4_lane_shift
    import lp_pkg::*;
#(
    parameter int NBITS = LP_NBITS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NSAMPS-1:0][NBITS-1:0]  dat_i,
    input  logic [1:0]                    sel_i,
    output logic [NSAMPS-1:0][NBITS-1:0]  sh_o
);

    logic [NSAMPS-1:0][NBITS-1:0] prev_q, prev_d;
    logic [NSAMPS-1:0][NBITS-1:0] sh_q, sh_d;

    always_comb begin
        logic [1:0] lane;
        logic [1:0] idx;
        lane   = '0;
        idx    = '0;
        prev_d = dat_i;
        sh_d   = '0;
        for (int k = 0; k < NSAMPS; k++) begin
            lane = 2'(k);
            // k-S and k-S+4 share the same low two bits, so one modulo-4
            // index serves both sources; only the source word differs.
            idx = lane - sel_i;
            if (lane >= sel_i) begin
                sh_d[k] = dat_i[idx];
            end else begin
                sh_d[k] = prev_q[idx];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
            sh_q   <= '0;
        end else begin
            prev_q <= prev_d;
            sh_q   <= sh_d;
        end
    end

    assign sh_o = sh_q;

endmodule

// File: rtl/ssr4_sample_align.sv
// ---------------------------------------------------------------------------
// ssr4_sample_align
// Programmable sample-granular delay D = 4*C + S for the SSR4 filter output,
// used to line channels up to a common sample. S lanes come from the lane
// shift stage, C whole clocks from a circular buffer. Fixed latency 2 clocks.
// After reset or any delay write, valid_o stays low for C+2 clocks while the
// history under the new delay fills.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   dat_i        : SSR4 input word, lane 0 oldest
//   dly_i        : requested delay D in samples
//   dly_wr_i     : load dly_i this clock (always restarts the flush)
//   dat_o        : delayed SSR4 word (updates even while flushing)
//   valid_o      : dat_o reflects the current delay over a flushed history
//   busy_o       : flush in progress, ~valid_o
// MAXCLKS is a power of two so that dly_i spans exactly 0..4*MAXCLKS-1 and
// the buffer pointers wrap naturally.
// ---------------------------------------------------------------------------
module ssr4_sample_align
    import lp_pkg::*;
#(
    parameter int  NBITS   = LP_NBITS,
    parameter int  MAXCLKS = 16,
    localparam int DLYBITS = $clog2(4 * MAXCLKS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NSAMPS-1:0][NBITS-1:0]  dat_i,
    input  logic [DLYBITS-1:0]            dly_i,
    input  logic                          dly_wr_i,
    output logic [NSAMPS-1:0][NBITS-1:0]  dat_o,
    output logic                          valid_o,
    output logic                          busy_o
);

    localparam int PW = DLYBITS - 2;            // buffer pointer width
    localparam int CW = $clog2(MAXCLKS + 3);    // flush counter, up to MAXCLKS+1

    typedef logic [NSAMPS-1:0][NBITS-1:0] word_t;

    logic [DLYBITS-1:0] dly_q, dly_d;
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               valid_q, valid_d;
    word_t              dat_q, dat_d;
    word_t              mem_q [MAXCLKS];
    word_t              mem_d [MAXCLKS];
    word_t              sh;
    logic [PW-1:0]      clks;
    logic [PW-1:0]      rd_addr;

    ssr4_lane_shift #(
        .NBITS (NBITS)
    ) u_shift (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .dat_i (dat_i),
        .sel_i (dly_q[1:0]),
        .sh_o  (sh)
    );

    always_comb begin
        dly_d   = dly_wr_i ? dly_i : dly_q;
        clks    = dly_q[DLYBITS-1:2];
        wptr_d  = wptr_q + PW'(1);
        // The word written C clocks ago sits C slots behind the write pointer.
        rd_addr = wptr_q - clks;
        mem_d   = mem_q;
        mem_d[wptr_q] = sh;
        // C=0 would read the slot being written this clock, so bypass it.
        dat_d   = (clks == '0) ? sh : mem_q[rd_addr];

        if (dly_wr_i) begin
            cnt_d = CW'(dly_i[DLYBITS-1:2]) + CW'(2);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // Registered from the old count, so a write drops valid one edge later.
        valid_d = (cnt_q == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q   <= '0;
            wptr_q  <= '0;
            cnt_q   <= CW'(2);
            valid_q <= 1'b0;
            dat_q   <= '0;
            for (int i = 0; i < MAXCLKS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dly_q   <= dly_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dat_q   <= dat_d;
            mem_q   <= mem_d;
        end
    end

    assign dat_o   = dat_q;
    assign valid_o = valid_q;
    assign busy_o  = ~valid_q;

endmodule
